// File: rtl/fetch_unit_if.sv
// Fetch-unit bus bundle: the instruction-memory request/response channel and
// the decode-facing instruction channel. The fetch unit is the master side.
interface fetch_unit_if;

    // Instruction-memory request channel
    logic        imemReqValid;
    logic        imemReqReady;
    logic [31:0] imemAddr;

    // Instruction-memory response channel (in order, always accepted)
    logic        imemRespValid;
    logic [31:0] imemRespData;

    // Decode-facing instruction channel
    logic        instrValid;
    logic        instrReady;
    logic [31:0] instr;
    logic [31:0] instrPc;

    modport master (
        output imemReqValid,
        output imemAddr,
        input  imemReqReady,
        input  imemRespValid,
        input  imemRespData,
        output instrValid,
        output instr,
        output instrPc,
        input  instrReady
    );

    modport slave (
        input  imemReqValid,
        input  imemAddr,
        output imemReqReady,
        output imemRespValid,
        output imemRespData,
        input  instrValid,
        input  instr,
        input  instrPc,
        output instrReady
    );

endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit. Holds the fetch pointer, issues word requests to
// instruction memory under a credit limit, buffers in-order responses with
// their PC and hands them to decode. A redirect flushes the buffer and marks
// every in-flight request so its response is discarded when it returns.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         redirect,
    input  logic [31:0]  redirectPc,
    fetch_unit_if.master bus
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // Wide enough to hold count + outstanding (at most 2*DEPTH) without overflow.
    localparam int unsigned CntW = $clog2(DEPTH + 1) + 1;

    localparam logic [CntW-1:0] DepthC  = CntW'(DEPTH);
    localparam logic [PtrW-1:0] LastPtr = PtrW'(DEPTH - 1);

    // Architectural state
    logic [31:0]     fetch_pc_q, fetch_pc_d;
    logic [31:0]     resp_pc_q, resp_pc_d;
    logic [CntW-1:0] count_q, count_d;
    logic [CntW-1:0] outst_q, outst_d;
    logic [CntW-1:0] drop_q, drop_d;
    logic [PtrW-1:0] head_q, head_d;
    logic [PtrW-1:0] tail_q, tail_d;

    // Instruction buffer storage; validity is tracked by count/head/tail only.
    logic [31:0]     buf_pc_q    [DEPTH];
    logic [31:0]     buf_instr_q [DEPTH];

    // Handshake decode
    logic            req_valid;
    logic            head_valid;
    logic            req_fire;
    logic            resp_fire;
    logic            pop_fire;
    logic            push;
    logic [CntW-1:0] inflight;
    logic [31:0]     redirect_pc_aligned;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == LastPtr) ? '0 : p + PtrW'(1);
    endfunction

    // Requests are allowed only while a buffer slot is reserved for every
    // fetch already buffered or in flight, so the buffer can never overflow.
    assign req_valid  = (count_q + outst_q) < DepthC;
    assign head_valid = (count_q != '0);

    assign req_fire  = req_valid & bus.imemReqReady;
    assign resp_fire = bus.imemRespValid;
    assign pop_fire  = head_valid & bus.instrReady;

    // Outstanding requests after this cycle's request and response.
    assign inflight = outst_q + CntW'(req_fire) - CntW'(resp_fire);

    assign redirect_pc_aligned = {redirectPc[31:2], 2'b00};

    assign bus.imemReqValid = req_valid;
    assign bus.imemAddr     = fetch_pc_q;
    assign bus.instrValid   = head_valid;
    assign bus.instr        = head_valid ? buf_instr_q[head_q] : '0;
    assign bus.instrPc      = head_valid ? buf_pc_q[head_q]    : '0;

    // Next-state: pointer advance, response drop/push, buffer bookkeeping.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        count_d    = count_q;
        outst_d    = inflight;
        drop_d     = drop_q;
        head_d     = head_q;
        tail_d     = tail_q;
        push       = 1'b0;

        if (redirect) begin
            // Everything still outstanding (including a request accepted this
            // cycle) belongs to the old path; a same-cycle response is simply
            // not pushed.
            fetch_pc_d = redirect_pc_aligned;
            resp_pc_d  = redirect_pc_aligned;
            count_d    = '0;
            head_d     = '0;
            tail_d     = '0;
            drop_d     = inflight;
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (resp_fire) begin
                if (drop_q != '0) begin
                    drop_d = drop_q - CntW'(1);
                end else begin
                    push      = 1'b1;
                    resp_pc_d = resp_pc_q + 32'd4;
                    tail_d    = ptr_inc(tail_q);
                end
            end
            if (pop_fire) begin
                head_d = ptr_inc(head_q);
            end
            count_d = count_q + CntW'(push) - CntW'(pop_fire);
        end
    end

    // Control state register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            count_q    <= '0;
            outst_q    <= '0;
            drop_q     <= '0;
            head_q     <= '0;
            tail_q     <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            count_q    <= count_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
        end
    end

    // Buffer write of a kept response at the tail slot.
    always_ff @(posedge clk) begin
        if (reset && push) begin
            buf_pc_q[tail_q]    <= resp_pc_q;
            buf_instr_q[tail_q] <= bus.imemRespData;
        end
    end

    // A kept response into a full buffer means the credit accounting is broken.
    buf_no_overflow_a : assert property (
        @(posedge clk) disable iff (!reset) !(push && (count_q == DepthC))
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a fixed-latency in-order memory model returns
// addr ^ 32'hA5A5_0000, and each scenario checks hand-computed outputs cycle by
// cycle after a fresh reset.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect;
    logic [31:0] redirectPc;

    fetch_unit_if bus ();

    fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .DEPTH    (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .redirect   (redirect),
        .redirectPc (redirectPc),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Memory model state
    int unsigned cyc     = 0;
    int unsigned mem_lat = 1;
    logic [31:0] q_addr [$];
    int unsigned q_due  [$];
    logic        mem_driving = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b0;
        redirect = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    // In-order memory: a request accepted at the edge ending cycle n is
    // presented as a response during cycle n + mem_lat.
    initial begin
        bus.imemRespValid = 1'b0;
        bus.imemRespData  = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                q_addr.delete();
                q_due.delete();
                mem_driving = 1'b0;
            end else if (bus.imemReqValid && bus.imemReqReady) begin
                q_addr.push_back(bus.imemAddr);
                q_due.push_back(cyc + mem_lat);
            end
            @(posedge clk);
            cyc++;
            #1;
            if (mem_driving && q_addr.size() > 0) begin
                void'(q_addr.pop_front());
                void'(q_due.pop_front());
            end
            mem_driving = 1'b0;
            if (q_addr.size() > 0) begin
                if (q_due[0] <= cyc) mem_driving = 1'b1;
            end
            bus.imemRespValid = mem_driving;
            bus.imemRespData  = mem_driving ? (q_addr[0] ^ 32'hA5A5_0000) : 32'h0;
        end
    end

    initial begin
        int unsigned n_pop;
        logic [31:0] exp_pc;

        reset            = 1'b0;
        redirect         = 1'b0;
        redirectPc       = '0;
        bus.imemReqReady = 1'b0;
        bus.instrReady   = 1'b0;

        // Reset state
        do_reset();
        check("rst_req_valid",   bus.imemReqValid, 32'd1);
        check("rst_addr",        bus.imemAddr,     32'h0);
        check("rst_instr_valid", bus.instrValid,   32'd0);
        check("rst_instr",       bus.instr,        32'h0);
        check("rst_instr_pc",    bus.instrPc,      32'h0);

        // Streaming, 1-cycle memory, decode always ready
        mem_lat          = 1;
        bus.imemReqReady = 1'b1;
        bus.instrReady   = 1'b1;
        tick();
        check("s_c1_req_valid", bus.imemReqValid, 32'd1);
        check("s_c1_addr",      bus.imemAddr,     32'h4);
        check("s_c1_valid",     bus.instrValid,   32'd0);
        tick();
        check("s_c2_req_valid", bus.imemReqValid, 32'd0);
        check("s_c2_valid",     bus.instrValid,   32'd1);
        check("s_c2_pc",        bus.instrPc,      32'h0);
        check("s_c2_instr",     bus.instr,        32'hA5A5_0000);
        n_pop  = 0;
        exp_pc = 32'h4;
        for (int i = 0; i < 12 && n_pop < 3; i++) begin
            tick();
            if (bus.instrValid) begin
                check("s_pc",    bus.instrPc, exp_pc);
                check("s_instr", bus.instr,   exp_pc ^ 32'hA5A5_0000);
                exp_pc = exp_pc + 32'd4;
                n_pop++;
            end
        end
        check("s_pops", n_pop, 32'd3);

        // Backpressure from decode
        bus.instrReady = 1'b0;
        do_reset();
        tick();
        tick();
        tick();
        check("bp_c3_req_valid", bus.imemReqValid, 32'd0);
        check("bp_c3_valid",     bus.instrValid,   32'd1);
        check("bp_c3_pc",        bus.instrPc,      32'h0);
        check("bp_c3_instr",     bus.instr,        32'hA5A5_0000);
        tick();
        check("bp_c4_req_valid", bus.imemReqValid, 32'd0);
        check("bp_c4_pc",        bus.instrPc,      32'h0);
        check("bp_c4_instr",     bus.instr,        32'hA5A5_0000);
        bus.instrReady = 1'b1;
        tick();
        check("bp_c5_pc",        bus.instrPc,      32'h4);
        check("bp_c5_instr",     bus.instr,        32'hA5A5_0004);
        check("bp_c5_req_valid", bus.imemReqValid, 32'd1);
        check("bp_c5_addr",      bus.imemAddr,     32'h8);
        tick();
        check("bp_c6_valid",     bus.instrValid,   32'd0);
        check("bp_c6_addr",      bus.imemAddr,     32'hC);

        // Memory stall for 5 cycles
        bus.imemReqReady = 1'b0;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            check("st_req_valid", bus.imemReqValid, 32'd1);
            check("st_addr",      bus.imemAddr,     32'h0);
            tick();
        end
        bus.imemReqReady = 1'b1;
        tick();
        bus.imemReqReady = 1'b0;
        check("st_c6_valid", bus.instrValid, 32'd0);
        check("st_c6_addr",  bus.imemAddr,   32'h4);
        tick();
        check("st_c7_valid", bus.instrValid, 32'd1);
        check("st_c7_pc",    bus.instrPc,    32'h0);
        check("st_c7_instr", bus.instr,      32'hA5A5_0000);

        // Redirect with two requests in flight, 3-cycle memory
        mem_lat          = 3;
        bus.imemReqReady = 1'b1;
        bus.instrReady   = 1'b1;
        do_reset();
        tick();
        tick();
        check("rd_c2_req_valid", bus.imemReqValid, 32'd0);
        redirect   = 1'b1;
        redirectPc = 32'h0000_0103;
        tick();
        redirect = 1'b0;
        check("rd_c3_addr",      bus.imemAddr,     32'h100);
        check("rd_c3_req_valid", bus.imemReqValid, 32'd0);
        check("rd_c3_valid",     bus.instrValid,   32'd0);
        tick();
        check("rd_c4_req_valid", bus.imemReqValid, 32'd1);
        check("rd_c4_addr",      bus.imemAddr,     32'h100);
        for (int i = 0; i < 10 && !bus.instrValid; i++) tick();
        check("rd_valid", bus.instrValid, 32'd1);
        check("rd_pc",    bus.instrPc,    32'h100);
        check("rd_instr", bus.instr,      32'hA5A5_0100);

        // Redirect in the same cycle as a request and a response
        mem_lat = 1;
        do_reset();
        tick();
        check("co_c1_req_valid", bus.imemReqValid, 32'd1);
        redirect   = 1'b1;
        redirectPc = 32'h0000_0200;
        tick();
        redirect = 1'b0;
        check("co_c2_valid",     bus.instrValid,   32'd0);
        check("co_c2_addr",      bus.imemAddr,     32'h200);
        check("co_c2_req_valid", bus.imemReqValid, 32'd1);
        tick();
        check("co_c3_valid",     bus.instrValid,   32'd0);
        check("co_c3_addr",      bus.imemAddr,     32'h204);
        tick();
        check("co_c4_valid",     bus.instrValid,   32'd1);
        check("co_c4_pc",        bus.instrPc,      32'h200);
        check("co_c4_instr",     bus.instr,        32'hA5A5_0200);

        // Address wrap, then reset with a full buffer
        bus.instrReady = 1'b0;
        do_reset();
        redirect   = 1'b1;
        redirectPc = 32'hFFFF_FFFC;
        tick();
        redirect = 1'b0;
        check("wr_c1_addr",      bus.imemAddr,     32'hFFFF_FFFC);
        check("wr_c1_valid",     bus.instrValid,   32'd0);
        tick();
        check("wr_c2_addr",      bus.imemAddr,     32'h0);
        tick();
        check("wr_c3_valid",     bus.instrValid,   32'd1);
        check("wr_c3_pc",        bus.instrPc,      32'hFFFF_FFFC);
        check("wr_c3_instr",     bus.instr,        32'h5A5A_FFFC);
        tick();
        check("wr_c4_req_valid", bus.imemReqValid, 32'd0);
        check("wr_c4_pc",        bus.instrPc,      32'hFFFF_FFFC);
        reset = 1'b0;
        tick();
        check("mr_valid",     bus.instrValid,   32'd0);
        check("mr_addr",      bus.imemAddr,     32'h0);
        check("mr_req_valid", bus.imemReqValid, 32'd1);
        check("mr_pc",        bus.instrPc,      32'h0);
        check("mr_instr",     bus.instr,        32'h0);
        reset = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch reader on the consumer side of the program-counter path. It holds the fetch pointer and issues word addresses to instruction memory over a valid/ready request channel. In-order responses are buffered with their PC and presented to decode over a valid/ready channel. A redirect from execute (branch/jump) flushes the buffer and discards in-flight responses.

Parameters:
RESET_PC, 32'h0000_0000, fetch pointer value after reset
DEPTH, 2, instruction buffer entries; also the cap on buffered plus in-flight fetches (credits)

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-low reset (0 = reset, sampled on rising clk)
redirect  input  1  flush and restart fetch at redirectPc
redirectPc  input  32  new fetch address; bits [1:0] ignored (forced 0)
imemReqValid  output  1  address request valid
imemReqReady  input  1  memory accepts request
imemAddr  output  32  request address = fetch pointer
imemRespValid  input  1  response valid; in order, one per accepted request, always accepted
imemRespData  input  32  instruction word
instrValid  output  1  buffer head valid
instrReady  input  1  decode accepts head
instr  output  32  head instruction
instrPc  output  32  PC of head instruction

Behaviour:
- Reset (reset==0 at edge): fetchPc=RESET_PC, respPc=RESET_PC, buffer count=0, outstanding=0, dropCount=0. Consequently imemReqValid=1 (DEPTH>0), imemAddr=RESET_PC, instrValid=0, instr=0, instrPc=0. Reset overrides redirect and all handshakes. Reset mid-operation discards everything; later responses to old requests are the memory's responsibility and are not dropped.
- State: fetchPc[31:0]; respPc[31:0] (PC of next expected kept response); outstanding (0..DEPTH); dropCount (0..DEPTH); buffer of DEPTH {pc,instr} entries, circular, head/tail/count.
- reqFire = imemReqValid & imemReqReady. respFire = imemRespValid. popFire = instrValid & instrReady.
- imemReqValid = (count + outstanding) < DEPTH. Combinational from state only; not a function of imemReqReady. imemAddr = fetchPc.
- On reqFire: fetchPc += 4 (wraps 32'hFFFF_FFFC -> 0); outstanding += 1.
- On respFire: outstanding -= 1. If dropCount>0: discard, dropCount -= 1. Otherwise push {respPc, imemRespData} and respPc += 4.
- Response and request in the same cycle: outstanding is unchanged.
- Credits guarantee the buffer never overflows. A response when count==DEPTH is impossible by construction; assert in simulation.
- instrValid = count!=0. instr/instrPc come from the head entry, combinationally; they hold 0 when empty. Pop on popFire. Push and pop in the same cycle leave count unchanged. With a response into an empty buffer, instrValid rises the cycle after respFire (1-cycle latency, no bypass).
- Redirect (reset==1, redirect==1), at the edge:
  - fetchPc = respPc = {redirectPc[31:2],2'b00}.
  - count, head, tail cleared. popFire that cycle is ignored; instrValid is 0 next cycle.
  - dropCount = outstanding + reqFire - respFire. This counts the request accepted in the redirect cycle; a response in the redirect cycle is discarded whatever dropCount was.
  - outstanding = outstanding + reqFire - respFire.
- A redirect while dropCount>0 keeps accumulating: the new dropCount equals all still-outstanding requests.
- No misaligned-PC trap; low bits are always zero.

Test Plan:
- Reset + streaming: hold reset=0 for 2 cycles, release, imemReqReady=1. Memory returns word = addr^32'hA5A5_0000 with 1-cycle latency, instrReady=1. Expect instrPc 0,4,8,12 in order, each instr matching; imemReqValid=0 never while count+outstanding<2.
- Backpressure: instrReady=0. After 2 requests, imemReqValid=0 and count=2, with instrPc=0 and instr held stable. Raise instrReady: pops 0 then 4, and requests resume at addr 8.
- Memory stall: imemReqReady=0 for 5 cycles. imemAddr holds 0 and imemReqValid stays 1. Fire at cycle 6; the instruction appears 2 cycles after the request.
- Redirect with 2 in flight: responses delayed 3 cycles, redirect to 32'h0000_0103. Next imemAddr=32'h100. The two old responses are dropped; the first instrPc=32'h100.
- Redirect coinciding with reqFire and respFire: outstanding=1. Expect dropCount=1, the same-cycle response discarded, the next response dropped, and the following one delivered with the redirect PC.
- Wrap + reset mid-op: redirect to 32'hFFFF_FFFC. Expect imemAddr sequence FFFF_FFFC, 0000_0000. Then assert reset with count=2: next cycle instrValid=0 and imemAddr=RESET_PC.
